// File: rtl/qspi_phy_os.sv
// ============================================================================
//  Module      : qspi_phy_os
//  Description : Oversampled QSPI target-side PHY. Synchronises SCK, CE# and
//                IO[3:0] into clk_i, detects SCK edges, and shifts a 1-lane
//                command phase followed by any number of 4-lane receive or
//                transmit phases sized by the controller on the txn* port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i       local clock, at least 8x the SCK frequency
//    reset_i     synchronous active-high reset
//    sck_i       SPI clock pin (mode 0)
//    ce_n_i      chip enable pin, active low
//    io_i        IO pin inputs (IO0 = MOSI in 1-lane mode)
//    io_o        IO pin output values
//    io_oe_o     IO output enables, active high
//    txnbc_i     SCK cycles in the current quad phase
//    txndir_i    0 = receive, 1 = transmit
//    txndata_i   word to transmit (right-justified)
//    txndata_o   received word, right-justified
//    txndone_o   one-cycle pulse when a phase completes
//    txnreset_o  one-cycle pulse on CE# deassertion
// ============================================================================
`default_nettype none

module qspi_phy_os #(
    parameter int IOREG_BITS       = 32,
    parameter int CYCLE_COUNT_BITS = 8,
    parameter int CMD_CYCLES       = 8,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        sck_i,
    input  logic                        ce_n_i,
    input  logic [3:0]                  io_i,
    output logic [3:0]                  io_o,
    output logic [3:0]                  io_oe_o,
    input  logic [CYCLE_COUNT_BITS-1:0] txnbc_i,
    input  logic                        txndir_i,
    input  logic [IOREG_BITS-1:0]       txndata_i,
    output logic [IOREG_BITS-1:0]       txndata_o,
    output logic                        txndone_o,
    output logic                        txnreset_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_QUAD = 2'd2
    } state_t;

    localparam logic [CYCLE_COUNT_BITS-1:0] CMD_CNT   = CYCLE_COUNT_BITS'(CMD_CYCLES);
    localparam logic [CYCLE_COUNT_BITS-1:0] CNT_ONE   = CYCLE_COUNT_BITS'(1);
    localparam logic [CYCLE_COUNT_BITS+1:0] IOREG_W   = (CYCLE_COUNT_BITS+2)'(IOREG_BITS);

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ce_sync_q;
    logic [3:0]             io_sync_q [SYNC_STAGES];
    logic                   sck_dly_q;
    logic                   ce_dly_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_sync_q <= '0;
            ce_sync_q  <= '1;
            sck_dly_q  <= 1'b0;
            ce_dly_q   <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                io_sync_q[i] <= 4'h0;
            end
        end else begin
            sck_sync_q[0] <= sck_i;
            ce_sync_q[0]  <= ce_n_i;
            io_sync_q[0]  <= io_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_q[i] <= sck_sync_q[i-1];
                ce_sync_q[i]  <= ce_sync_q[i-1];
                io_sync_q[i]  <= io_sync_q[i-1];
            end
            sck_dly_q <= sck_sync_q[SYNC_STAGES-1];
            ce_dly_q  <= ce_sync_q[SYNC_STAGES-1];
        end
    end

    logic       sck_s;
    logic       ce_s;
    logic [3:0] io_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       ce_rise;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ce_s     = ce_sync_q[SYNC_STAGES-1];
    assign io_s     = io_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign ce_rise  = ce_s & ~ce_dly_q;

    // ------------------------------------------------------------------
    // Phase datapath
    // ------------------------------------------------------------------
    state_t                      state_q;
    logic [CYCLE_COUNT_BITS-1:0] cnt_q;
    logic [CYCLE_COUNT_BITS-1:0] bc_q;
    logic                        dir_q;
    logic                        cap_q;
    logic [IOREG_BITS-1:0]       rx_q;
    logic [IOREG_BITS-1:0]       tx_q;
    logic [3:0]                  io_q;
    logic [3:0]                  io_oe_q;
    logic [IOREG_BITS-1:0]       txndata_q;
    logic                        txndone_q;
    logic                        txnreset_q;

    logic [CYCLE_COUNT_BITS-1:0] bc_eff;
    logic                        dir_eff;
    logic [CYCLE_COUNT_BITS-1:0] cnt_d;
    logic [IOREG_BITS-1:0]       rx1_d;
    logic [IOREG_BITS-1:0]       rx4_d;
    logic [CYCLE_COUNT_BITS+1:0] bc4;
    logic [CYCLE_COUNT_BITS+1:0] shamt;
    logic [IOREG_BITS-1:0]       tx_load_d;
    logic [IOREG_BITS-1:0]       tx_shift_d;
    logic                        quad_last;

    // Until the first SCK fall of a phase has latched the phase setup, the
    // live controller inputs apply (a receive phase may begin on a rise).
    assign bc_eff  = cap_q ? bc_q  : txnbc_i;
    assign dir_eff = cap_q ? dir_q : txndir_i;

    // Saturating increment: an illegal zero-length phase parks the counter.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    assign rx1_d = {rx_q[IOREG_BITS-2:0], io_s[0]};
    assign rx4_d = {rx_q[IOREG_BITS-5:0], io_s};

    // Left-justify the transmit word so its first nibble sits at the top.
    // Phases longer than the register simply send the word unshifted.
    assign bc4        = {txnbc_i, 2'b00};
    assign shamt      = (bc4 >= IOREG_W) ? '0 : (IOREG_W - bc4);
    assign tx_load_d  = txndata_i << shamt;
    assign tx_shift_d = {tx_q[IOREG_BITS-5:0], 4'h0};

    assign quad_last = (bc_eff != '0) && (cnt_d == bc_eff);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bc_q       <= '0;
            dir_q      <= 1'b0;
            cap_q      <= 1'b0;
            rx_q       <= '0;
            tx_q       <= '0;
            io_q       <= 4'h0;
            io_oe_q    <= 4'h0;
            txndata_q  <= '0;
            txndone_q  <= 1'b0;
            txnreset_q <= 1'b0;
        end else begin
            txndone_q  <= 1'b0;
            txnreset_q <= 1'b0;

            // CE# deassertion aborts everything, including an SCK edge
            // detected in the same cycle.
            if (ce_rise) begin
                txnreset_q <= 1'b1;
                io_oe_q    <= 4'h0;
                cnt_q      <= '0;
                cap_q      <= 1'b0;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        io_oe_q <= 4'h0;
                        if (!ce_s) begin
                            cnt_q   <= '0;
                            rx_q    <= '0;
                            tx_q    <= '0;
                            cap_q   <= 1'b0;
                            state_q <= ST_CMD;
                        end
                    end

                    ST_CMD: begin
                        if (sck_rise) begin
                            if (cnt_d == CMD_CNT) begin
                                txndone_q <= 1'b1;
                                txndata_q <= rx1_d;
                                rx_q      <= '0;
                                cnt_q     <= '0;
                                cap_q     <= 1'b0;
                                state_q   <= ST_QUAD;
                            end else begin
                                rx_q  <= rx1_d;
                                cnt_q <= cnt_d;
                            end
                        end
                    end

                    ST_QUAD: begin
                        if (sck_rise) begin
                            if (quad_last) begin
                                txndone_q <= 1'b1;
                                txndata_q <= dir_eff ? rx_q : rx4_d;
                                rx_q      <= '0;
                                cnt_q     <= '0;
                                cap_q     <= 1'b0;
                                io_oe_q   <= 4'h0;
                            end else begin
                                if (!dir_eff) begin
                                    rx_q <= rx4_d;
                                end
                                cnt_q <= cnt_d;
                            end
                        end else if (sck_fall) begin
                            if (!cap_q && (cnt_q == '0)) begin
                                // First fall of the phase: latch its setup and,
                                // for transmit, present the first nibble.
                                cap_q <= 1'b1;
                                bc_q  <= txnbc_i;
                                dir_q <= txndir_i;
                                if (txndir_i) begin
                                    tx_q    <= tx_load_d;
                                    io_q    <= tx_load_d[IOREG_BITS-1 -: 4];
                                    io_oe_q <= 4'hF;
                                end
                            end else if (cap_q && dir_q) begin
                                tx_q <= tx_shift_d;
                                io_q <= tx_shift_d[IOREG_BITS-1 -: 4];
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_o       = io_q;
    assign io_oe_o    = io_oe_q;
    assign txndata_o  = txndata_q;
    assign txndone_o  = txndone_q;
    assign txnreset_o = txnreset_q;

endmodule

`default_nettype wire

// File: tb/tb_qspi_phy_os.sv
// ============================================================================
//  Module      : tb_qspi_phy_os
//  Description : Directed, table-driven bench for qspi_phy_os. Drives SCK in
//                mode 0 with a half period of 8 clk_i cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_phy_os;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        sck_i;
    logic        ce_n_i;
    logic [3:0]  io_i;
    logic [3:0]  io_o;
    logic [3:0]  io_oe_o;
    logic [7:0]  txnbc_i;
    logic        txndir_i;
    logic [31:0] txndata_i;
    logic [31:0] txndata_o;
    logic        txndone_o;
    logic        txnreset_o;

    always #5 clk = ~clk;

    qspi_phy_os #(
        .IOREG_BITS      (32),
        .CYCLE_COUNT_BITS(8),
        .CMD_CYCLES      (8),
        .SYNC_STAGES     (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .sck_i     (sck_i),
        .ce_n_i    (ce_n_i),
        .io_i      (io_i),
        .io_o      (io_o),
        .io_oe_o   (io_oe_o),
        .txnbc_i   (txnbc_i),
        .txndir_i  (txndir_i),
        .txndata_i (txndata_i),
        .txndata_o (txndata_o),
        .txndone_o (txndone_o),
        .txnreset_o(txnreset_o)
    );

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    int rst_cnt = 0;

    // Pulse counters; each pulse is one clk wide so it is counted once.
    always @(posedge clk) begin
        if (txndone_o)  done_cnt++;
        if (txnreset_o) rst_cnt++;
    end

    typedef struct {
        bit          cmd;       // 1-lane command phase
        logic [7:0]  bc;        // quad phase length
        logic        dir;       // 1 = DUT transmits
        logic [31:0] txd;       // word given to the DUT
        logic [63:0] drive;     // bits/nibbles the host drives, MSB first
        logic [63:0] exp_io;    // nibbles the DUT must present, MSB first
        logic [31:0] exp_data;  // txndata_o after the phase
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive data, raise SCK, and leave 6 clk for the DUT to react before the fall.
    task automatic sck_rise(input logic [3:0] d, output logic [3:0] io_s, output logic [3:0] oe_s);
        io_i = d;
        wait_clk(HALF);
        io_s = io_o;
        oe_s = io_oe_o;
        sck_i = 1'b1;
        wait_clk(HALF - 2);
    endtask

    task automatic sck_fall();
        wait_clk(2);
        sck_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] bc, input logic dir, input logic [31:0] d);
        txnbc_i   = bc;
        txndir_i  = dir;
        txndata_i = d;
    endtask

    // 1-lane command; the next phase setup is applied before the final fall.
    task automatic run_cmd(input logic [7:0] b, input logic [7:0] nbc, input logic ndir,
                           input logic [31:0] nd, input string nm);
        int d0;
        logic [3:0] s_io, s_oe;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) begin
            sck_rise({3'b000, b[7-k]}, s_io, s_oe);
            if (k == 7) begin
                chk({nm, " done"}, 64'(done_cnt - d0), 64'd1);
                chk({nm, " data"}, 64'(txndata_o), 64'(b));
                set_cfg(nbc, ndir, nd);
            end
            sck_fall();
        end
    endtask

    int         n;
    int         d0;
    int         r0;
    logic [3:0] nib;
    logic [3:0] s_io;
    logic [3:0] s_oe;

    initial begin
        vt[0] = '{1'b1, 8'd0,  1'b0, 32'h0,        64'hEB,           64'h0,        32'h000000EB};
        vt[1] = '{1'b0, 8'd8,  1'b0, 32'h0,        64'h12345678,     64'h0,        32'h12345678};
        vt[2] = '{1'b0, 8'd8,  1'b1, 32'hDEADBEEF, 64'h0,            64'hDEADBEEF, 32'h00000000};
        vt[3] = '{1'b0, 8'd2,  1'b1, 32'h000000A5, 64'h0,            64'hA5,       32'h00000000};
        vt[4] = '{1'b0, 8'd2,  1'b0, 32'h0,        64'h3C,           64'h0,        32'h0000003C};
        vt[5] = '{1'b0, 8'd10, 1'b0, 32'h0,        64'h123456789A,   64'h0,        32'h3456789A};
        vt[6] = '{1'b0, 8'd3,  1'b1, 32'h00000ABC, 64'h0,            64'hABC,      32'h00000000};

        reset_i = 1'b1;
        sck_i   = 1'b0;
        ce_n_i  = 1'b1;
        io_i    = 4'h0;
        set_cfg(8'd0, 1'b0, 32'h0);
        wait_clk(4);
        chk("reset io_o",       64'(io_o),       64'h0);
        chk("reset io_oe_o",    64'(io_oe_o),    64'h0);
        chk("reset txndata_o",  64'(txndata_o),  64'h0);
        chk("reset txndone_o",  64'(txndone_o),  64'h0);
        chk("reset txnreset_o", 64'(txnreset_o), 64'h0);
        reset_i = 1'b0;
        wait_clk(4);

        // ---------------- table-driven phases in one CE# frame ----------
        ce_n_i = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < NV; i++) begin
            n  = vt[i].cmd ? 8 : int'(vt[i].bc);
            d0 = done_cnt;
            for (int k = 0; k < n; k++) begin
                if (vt[i].cmd)      nib = {3'b000, vt[i].drive[n-1-k]};
                else if (vt[i].dir) nib = 4'h0;
                else                nib = vt[i].drive[4*(n-1-k) +: 4];
                sck_rise(nib, s_io, s_oe);
                if (!vt[i].cmd && vt[i].dir) begin
                    chk($sformatf("v%0d io nib%0d", i, k), 64'(s_io), 64'(vt[i].exp_io[4*(n-1-k) +: 4]));
                    chk($sformatf("v%0d oe nib%0d", i, k), 64'(s_oe), 64'hF);
                end else begin
                    chk($sformatf("v%0d oe idle%0d", i, k), 64'(s_oe), 64'h0);
                end
                if (k < n - 1) begin
                    chk($sformatf("v%0d early done%0d", i, k), 64'(done_cnt - d0), 64'd0);
                end else begin
                    chk($sformatf("v%0d done", i), 64'(done_cnt - d0), 64'd1);
                    chk($sformatf("v%0d data", i), 64'(txndata_o), 64'(vt[i].exp_data));
                    chk($sformatf("v%0d oe after", i), 64'(io_oe_o), 64'h0);
                    if (i + 1 < NV) set_cfg(vt[i+1].bc, vt[i+1].dir, vt[i+1].txd);
                end
                sck_fall();
            end
        end
        wait_clk(HALF);
        r0 = rst_cnt;
        ce_n_i = 1'b1;
        wait_clk(6);
        chk("frame end txnreset", 64'(rst_cnt - r0), 64'd1);
        wait_clk(HALF);

        // ---------------- CE# abort after 3 of 8 quad cycles ------------
        ce_n_i = 1'b0;
        wait_clk(HALF);
        run_cmd(8'hEB, 8'd8, 1'b0, 32'h0, "abort cmd");
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            sck_rise(4'(k + 1), s_io, s_oe);
            sck_fall();
        end
        wait_clk(HALF);
        r0 = rst_cnt;
        ce_n_i = 1'b1;
        wait_clk(6);
        chk("abort txnreset", 64'(rst_cnt - r0), 64'd1);
        chk("abort no done",  64'(done_cnt - d0), 64'd0);
        chk("abort oe",       64'(io_oe_o), 64'h0);
        chk("abort data held", 64'(txndata_o), 64'hEB);
        wait_clk(HALF);
        ce_n_i = 1'b0;
        wait_clk(HALF);
        run_cmd(8'h9F, 8'd3, 1'b1, 32'h00000ABC, "recmd 9F");

        // ---------------- reset mid-transmit with CE# held low ----------
        for (int k = 0; k < 2; k++) begin
            sck_rise(4'h0, s_io, s_oe);
            chk($sformatf("pre-reset io%0d", k), 64'(s_io), (k == 0) ? 64'hA : 64'hB);
            sck_fall();
        end
        wait_clk(4);
        chk("pre-reset oe", 64'(io_oe_o), 64'hF);
        reset_i = 1'b1;
        wait_clk(1);
        chk("midreset io_o",       64'(io_o),       64'h0);
        chk("midreset io_oe_o",    64'(io_oe_o),    64'h0);
        chk("midreset txndata_o",  64'(txndata_o),  64'h0);
        chk("midreset txndone_o",  64'(txndone_o),  64'h0);
        chk("midreset txnreset_o", 64'(txnreset_o), 64'h0);
        reset_i = 1'b0;
        wait_clk(HALF);
        run_cmd(8'h5A, 8'd8, 1'b0, 32'h0, "post-reset cmd");
        wait_clk(HALF);
        ce_n_i = 1'b1;
        wait_clk(HALF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qspi_phy_os.md
Name: qspi_phy_os

Overview:
- Oversampled QSPI target-side PHY that sits directly upstream of the QSPI controller FSM, on its txn* interface.
- Synchronises the external SCK, CE# and IO[3:0] pins into clk_i and runs every phase from the same initial values.
- Shifts command, address, wait and data phases in or out using the bit count and direction the controller supplies per phase.
- Reports each completed phase, and each CE# deassertion, to the controller.

Parameters:
IOREG_BITS, 32, width of the txndata words.
CYCLE_COUNT_BITS, 8, width of txnbc_i.
CMD_CYCLES, 8, SCK cycles in the 1-lane command phase.
SYNC_STAGES, 2, flip-flop synchroniser depth on sck_i, ce_n_i and io_i.

Ports:
clk_i  in  1  local clock; must be at least 8x the SCK frequency.
reset_i  in  1  synchronous, active-high reset.
sck_i  in  1  SPI clock pin; SPI mode 0.
ce_n_i  in  1  chip enable pin, active low.
io_i  in  4  IO pin inputs; IO0 = MOSI in 1-lane mode.
io_o  out  4  IO pin output values.
io_oe_o  out  4  IO output enables, active high.
txnbc_i  in  CYCLE_COUNT_BITS  SCK cycles in the current phase.
txndir_i  in  1  0 = receive, 1 = transmit.
txndata_i  in  IOREG_BITS  word to transmit.
txndata_o  out  IOREG_BITS  received word, right-justified.
txndone_o  out  1  one-cycle pulse when a phase completes.
txnreset_o  out  1  one-cycle pulse on CE# deassertion.

Behaviour:
- Synchroniser chains:
  - sck_s, ce_s and io_s are each SYNC_STAGES flops.
  - sck_s and ce_s reset to 0 and 1 respectively.
  - sck_rise / sck_fall come from comparing sck_s with a 1-flop delayed copy.
  - Pin-to-detect latency is SYNC_STAGES+1 clk_i cycles.
- State machine, 2 bits; reset state IDLE:
  - IDLE: io_oe_o = 0. When ce_s = 0, clear the counter and shift registers and go to CMD.
  - CMD:
    - 1-lane receive of CMD_CYCLES cycles, independent of txnbc_i / txndir_i.
    - On each sck_rise: rx = {rx[IOREG_BITS-2:0], io_s[0]}, cnt += 1.
    - When cnt reaches CMD_CYCLES: txndone_o = 1 for one cycle, cnt = 0, go to QUAD.
  - QUAD, receive (txndir_i = 0):
    - On each sck_rise: rx = {rx[IOREG_BITS-5:0], io_s[3:0]}, cnt += 1.
    - io_oe_o = 0.
  - QUAD, transmit (txndir_i = 1):
    - txnbc_i, txndir_i and txndata_i are captured on the first sck_fall of the phase (cnt = 0).
    - On that edge: tx = txndata_i << (IOREG_BITS - 4*txnbc_i), and io_o = the new tx top nibble.
    - On each later sck_fall: tx <<= 4, io_o = the new top nibble.
    - cnt increments on sck_rise.
    - io_oe_o = 4'hF from the capturing sck_fall until phase end or CE# deassertion.
  - QUAD, phase completion:
    - When cnt reaches the captured txnbc: txndone_o = 1 for one cycle, cnt = 0, stay in QUAD for the next phase.
    - A receive phase with no preceding sck_fall (the phase starts on a rising edge) uses the live txnbc_i.
- txndata_o:
  - Updated only in the txndone_o cycle.
  - Holds rx including the final bit/nibble; bits above 4*txnbc are zero because rx is cleared at each phase start.
  - Holds its value otherwise.
- txnbc = 0 in QUAD: the phase never completes and the counter saturates; the controller must not issue it.
- txnbc > IOREG_BITS/4: earliest nibbles are shifted out and lost; the word keeps the last IOREG_BITS bits.
- CE# deassertion:
  - On ce_s rising, from any state including mid-phase, txnreset_o pulses for one cycle.
  - Same cycle: io_oe_o = 0, cnt = 0, go to IDLE.
  - No txndone_o is issued for the partial phase.
- Simultaneous CE# rise and sck edge: CE# wins and the edge is ignored.
- Reset values:
  - io_o = 0, io_oe_o = 0, txndata_o = 0, txndone_o = 0, txnreset_o = 0.
  - cnt = 0, state IDLE.
- reset_i mid-transaction:
  - Returns everything to reset values.
  - If CE# is still low, the next transaction is entered as CMD; the host must re-frame with CE#.
- The counter is CYCLE_COUNT_BITS wide and never wraps within a legal phase.

Test Plan:
- Command 0xEB, 1-lane on IO0, 8 SCK -> exactly one txndone_o; txndata_o = 0x000000EB; io_oe_o stays 0.
- After the command, txnbc = 8, dir = 0, nibbles 1,2,...,8 -> txndone_o; txndata_o = 0x12345678.
- txnbc = 8, dir = 1, txndata_i = 0xDEADBEEF -> io_o sequence D,E,A,D,B,E,E,F sampled on successive SCK rises; io_oe_o = F during the phase, 0 after txndone_o.
- txnbc = 2, dir = 1, txndata_i = 0x000000A5 -> io_o = A then 5; txndone_o after 2 SCK.
- CE# raised after 3 of 8 quad cycles -> txnreset_o pulses once; no txndone_o; io_oe_o = 0; the next CE# low starts in CMD (verify with command 0x9F).
- reset_i asserted mid-phase with CE# held low -> all outputs 0 the next cycle; the following 8 SCK are decoded as a 1-lane command.
